// File: rtl/baud_tick_gen.sv
// Baud tick generator: a programmable divisor produces an rx oversample tick and a tx bit tick.
// Ticks are registered: the first os_tick lands divisor+1 clks after the DB_HI write edge; no backpressure.
module baud_tick_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_bus,
  input  logic [1:0]        ioaddr,
  input  logic              iocs,
  input  logic              iorw,
  output logic [DATA_W-1:0] rd_data,
  output logic              os_tick,
  output logic              bit_tick
);

  localparam int              OSW     = $clog2(OVS);
  localparam logic [OSW-1:0]  OS_LAST = OSW'(OVS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   shadow_lo_q, shadow_lo_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [OSW-1:0]      os_cnt_q, os_cnt_d;
  logic                os_tick_q, os_tick_d;
  logic                bit_tick_q, bit_tick_d;

  logic                wr_lo, wr_hi, tick_now;
  logic [2*DATA_W-1:0] wr_word;

  assign wr_lo   = iocs & ~iorw & (ioaddr == 2'b10);
  assign wr_hi   = iocs & ~iorw & (ioaddr == 2'b11);
  assign wr_word = {data_bus, shadow_lo_q};

  // A DB_HI write on the terminal-count cycle suppresses that tick in favour of the reload.
  assign tick_now = (div_q != '0) && (div_cnt_q == '0) && !wr_hi;

  always_comb begin
    div_d       = div_q;
    shadow_lo_d = shadow_lo_q;
    div_cnt_d   = div_cnt_q;
    os_cnt_d    = os_cnt_q;

    if (wr_lo) begin
      shadow_lo_d = data_bus;
    end

    if (wr_hi) begin
      div_d     = wr_word[DIV_W-1:0];
      div_cnt_d = wr_word[DIV_W-1:0];
      os_cnt_d  = '0;
    end else if (div_q != '0) begin
      if (div_cnt_q == '0) begin
        div_cnt_d = div_q;
        os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
      end else begin
        div_cnt_d = div_cnt_q - DIV_W'(1);
      end
    end

    os_tick_d  = tick_now;
    bit_tick_d = tick_now && (os_cnt_q == OS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      shadow_lo_q <= '0;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      shadow_lo_q <= shadow_lo_d;
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;

  always_comb begin
    rd_data = '0;
    if (iocs && iorw) begin
      case (ioaddr)
        2'b10:   rd_data = div_q[DATA_W-1:0];
        2'b11:   rd_data[DIV_W-DATA_W-1:0] = div_q[DIV_W-1:DATA_W];
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: expected tick cycles are queued at each DB_HI write
// and popped by a negedge monitor as the DUT emits os_tick.
module tb_baud_tick_gen;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_bus;
  logic [1:0] ioaddr;
  logic       iocs;
  logic       iorw;
  logic [7:0] rd_data;
  logic       os_tick;
  logic       bit_tick;

  baud_tick_gen #(.DATA_W(8), .DIV_W(16), .OVS(OVS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_bus (data_bus),
    .ioaddr   (ioaddr),
    .iocs     (iocs),
    .iorw     (iorw),
    .rd_data  (rd_data),
    .os_tick  (os_tick),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit b;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   tick_seen = 0;
  bit   strict    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every os_tick must match the head of the scoreboard while strict.
  always @(negedge clk) begin
    exp_t e;
    chk_eq("bit_without_os", {31'd0, bit_tick & ~os_tick}, 32'd0);
    if (os_tick === 1'b1) begin
      tick_seen++;
      if (strict) begin
        chk_eq("tick_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_eq("tick_cycle", cyc, e.t);
          chk_eq("bit_tick", {31'd0, bit_tick}, {31'd0, e.b});
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d, output int e);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; data_bus = d;
    @(posedge clk);
    #1;
    e = cyc;
    iocs = 1'b0; data_bus = '0;
  endtask

  task automatic rd(input string tag, input logic cs, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    iocs = cs; iorw = 1'b1; ioaddr = a;
    #1;
    chk_eq(tag, {24'd0, rd_data}, {24'd0, exp});
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ticks(input int e, input int per, input int n);
    for (int k = 1; k <= n; k++) begin
      exp_t x;
      x.t = e + k * per;
      x.b = (k % OVS) == 0;
      sb.push_back(x);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk_eq(tag, sb.size(), 0);
    strict = 1'b0;
    sb.delete();
  endtask

  initial begin
    int e0, e2, e3, ed, n;

    rst_n = 1'b0; iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10; data_bus = '0;
    #2;
    chk_eq("rst_os_tick", {31'd0, os_tick}, 32'd0);
    chk_eq("rst_bit_tick", {31'd0, bit_tick}, 32'd0);
    chk_eq("rst_rd_data", {24'd0, rd_data}, 32'd0);
    iocs = 1'b0; iorw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    tick_seen = 0;
    strict = 1'b1;
    repeat (1000) @(posedge clk);
    strict = 1'b0;
    chk_eq("idle_no_ticks", tick_seen, 0);
    rd("idle_rd_lo", 1'b1, 2'b10, 8'h00);
    rd("idle_rd_hi", 1'b1, 2'b11, 8'h00);

    // 2: divisor 3
    wr(2'b10, 8'h03, ed);
    wr(2'b11, 8'h00, e0);
    push_ticks(e0, 4, 20);
    strict = 1'b1;
    drain("div3_drain", 200);

    // 3: divisor 0x145, ignored addresses, readback
    wr(2'b10, 8'h45, ed);
    wr(2'b11, 8'h01, e0);
    push_ticks(e0, 326, 3);
    strict = 1'b1;
    wr(2'b00, 8'hAA, ed);
    wr(2'b01, 8'h55, ed);
    rd("rd_lo_145", 1'b1, 2'b10, 8'h45);
    rd("rd_hi_145", 1'b1, 2'b11, 8'h01);
    rd("rd_no_cs", 1'b0, 2'b10, 8'h00);
    rd("rd_addr01", 1'b1, 2'b01, 8'h00);
    drain("div325_drain", 1100);

    // 4: DB_LO write alone leaves the period alone
    wr(2'b10, 8'h03, ed);
    wr(2'b11, 8'h00, e0);
    push_ticks(e0, 4, 6);
    strict = 1'b1;
    goto(e0 + 9);
    wr(2'b10, 8'h07, ed);
    goto(e0 + 25);
    chk_eq("lo_only_pre_hi", sb.size(), 0);
    wr(2'b11, 8'h00, e2);
    push_ticks(e2, 8, 4);
    drain("div7_drain", 100);

    // 5: DB_HI write on the terminal-count cycle
    goto(e2 + 35);
    wr(2'b10, 8'h01, ed);
    goto(e2 + 39);
    wr(2'b11, 8'h00, e3);
    push_ticks(e3, 2, 16);
    strict = 1'b1;
    drain("collide_drain", 60);

    // 6: asynchronous reset mid-run
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
    n = 0;
    while (os_tick !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_eq("pre_rst_tick", {31'd0, os_tick}, 32'd1);
    chk_eq("pre_rst_rd", {24'd0, rd_data}, 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_os_tick", {31'd0, os_tick}, 32'd0);
    chk_eq("arst_bit_tick", {31'd0, bit_tick}, 32'd0);
    chk_eq("arst_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; iocs = 1'b0; iorw = 1'b0;
    tick_seen = 0;
    strict = 1'b1;
    repeat (200) @(posedge clk);
    chk_eq("post_rst_idle", tick_seen, 0);
    wr(2'b11, 8'h00, ed);
    repeat (50) @(posedge clk);
    chk_eq("shadow_cleared_idle", tick_seen, 0);
    rd("post_rst_rd_lo", 1'b1, 2'b10, 8'h00);
    strict = 1'b0;
    wr(2'b10, 8'h02, ed);
    wr(2'b11, 8'h00, e0);
    push_ticks(e0, 3, 3);
    strict = 1'b1;
    drain("post_rst_drain", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
